lfsr_rng_arbiter: RTL and testbench

//  Shares one 64-bit XNOR Fibonacci LFSR between NUM_REQ requesters as a random-word server.

---
 rtl/lfsr_pkg.sv | 24 ++
 rtl/lfsr_rng_arbiter_if.sv | 27 ++
 rtl/lfsr64_step.sv | 26 ++
 rtl/lfsr_rng_arbiter.sv | 134 +++++++++++++
 tb/tb_lfsr_rng_arbiter.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/lfsr_pkg.sv
// Shared constants, FSM state type and LFSR next-state helper for the RNG arbiter.
package lfsr_pkg;

  localparam int LFSR_W = 64;
  localparam int TAP_A  = 63;
  localparam int TAP_B  = 62;
  localparam int TAP_C  = 60;
  localparam int TAP_D  = 59;

  // XNOR feedback: all-ones maps to itself and is never allowed in the register.
  localparam logic [LFSR_W-1:0] LOCKUP = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    WARM  = 2'd1,
    READY = 2'd2,
    STEP  = 2'd3
  } state_t;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ~(s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D])};
  endfunction

endpackage

// File: rtl/lfsr_rng_arbiter_if.sv
// Requester-side bus of the RNG arbiter: seeding, level requests, grants and words.
interface lfsr_rng_arbiter_if
  import lfsr_pkg::*;
#(
  parameter int NUM_REQ = 4
) ();

  logic               seed_valid;
  logic [LFSR_W-1:0]  seed;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic               rnd_valid;
  logic [LFSR_W-1:0]  rnd_data;
  logic               busy;
  logic               seed_err;

  modport master (
    output seed_valid, seed, req,
    input  gnt, rnd_valid, rnd_data, busy, seed_err
  );

  modport slave (
    input  seed_valid, seed, req,
    output gnt, rnd_valid, rnd_data, busy, seed_err
  );

endinterface

// File: rtl/lfsr64_step.sv
// 64-bit XNOR Fibonacci LFSR register with parallel load and step enable.
module lfsr64_step
  import lfsr_pkg::*;
#(
  parameter logic [LFSR_W-1:0] DEFAULT_SEED = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] value
);

  // Load has priority over stepping; the register holds otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      value <= DEFAULT_SEED;
    end else if (load) begin
      value <= seed;
    end else if (step) begin
      value <= lfsr_next(value);
    end
  end

endmodule

// File: rtl/lfsr_rng_arbiter.sv
// Round-robin server of pseudo-random words from one shared LFSR, with
// seed/warm-up/skip sequencing.
//
// state | meaning
// LOAD  | pending seed is written into the LFSR this cycle
// WARM  | LFSR steps WARMUP times before the first grant
// READY | idle, grants the next requester round-robin
// STEP  | LFSR steps SKIP times after a grant
module lfsr_rng_arbiter
  import lfsr_pkg::*;
#(
  parameter int                NUM_REQ      = 4,
  parameter int                SKIP         = 4,
  parameter int                WARMUP       = 16,
  parameter logic [LFSR_W-1:0] DEFAULT_SEED = 64'h0
) (
  input logic            clk,
  input logic            reset,
  lfsr_rng_arbiter_if.slave bus
);

  localparam int CNT_MAX = (SKIP > WARMUP) ? SKIP : WARMUP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int PTR_W   = $clog2(NUM_REQ);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [PTR_W-1:0]   rr_ptr;
  logic [LFSR_W-1:0]  load_val;
  logic               load_bad;
  logic [LFSR_W-1:0]  lfsr_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic               rnd_valid_q;
  logic [LFSR_W-1:0]  rnd_data_q;
  logic               seed_err_q;

  logic                 pick_found;
  logic [PTR_W-1:0]     pick_idx;
  logic [2*NUM_REQ-1:0] req_rot;
  logic                 lfsr_load;
  logic                 lfsr_step;

  // A seed pulse pre-empts both the pending load and any stepping in the same cycle.
  assign lfsr_load = (state == LOAD) && !bus.seed_valid;
  assign lfsr_step = ((state == WARM) || (state == STEP)) && !bus.seed_valid;

  lfsr64_step #(
    .DEFAULT_SEED (DEFAULT_SEED)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (lfsr_load),
    .step  (lfsr_step),
    .seed  (load_val),
    .value (lfsr_q)
  );

  // Round-robin pick: first set request at or after rr_ptr, wrapping.
  always_comb begin
    int sum;
    pick_found = 1'b0;
    pick_idx   = '0;
    sum        = 0;
    req_rot    = {bus.req, bus.req} >> rr_ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!pick_found && req_rot[i]) begin
        pick_found = 1'b1;
        sum        = int'(rr_ptr) + i;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        pick_idx   = PTR_W'(sum);
      end
    end
  end

  // Sequencing FSM; grant, word and error pulse are registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= LOAD;
      cnt         <= '0;
      rr_ptr      <= '0;
      load_val    <= DEFAULT_SEED;
      load_bad    <= 1'b0;
      gnt_q       <= '0;
      rnd_valid_q <= 1'b0;
      rnd_data_q  <= '0;
      seed_err_q  <= 1'b0;
    end else begin
      gnt_q       <= '0;
      rnd_valid_q <= 1'b0;
      seed_err_q  <= 1'b0;
      if (bus.seed_valid) begin
        state    <= LOAD;
        cnt      <= '0;
        load_bad <= (bus.seed == LOCKUP);
        load_val <= (bus.seed == LOCKUP) ? DEFAULT_SEED : bus.seed;
      end else begin
        case (state)
          LOAD: begin
            seed_err_q <= load_bad;
            load_bad   <= 1'b0;
            if (WARMUP > 0) begin
              state <= WARM;
              cnt   <= CNT_W'(WARMUP);
            end else begin
              state <= READY;
            end
          end
          WARM, STEP: begin
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) state <= READY;
          end
          READY: begin
            if (pick_found) begin
              gnt_q       <= NUM_REQ'(1) << pick_idx;
              rnd_valid_q <= 1'b1;
              rnd_data_q  <= lfsr_q;
              rr_ptr      <= (pick_idx == PTR_W'(NUM_REQ - 1)) ? '0 : pick_idx + PTR_W'(1);
              state       <= STEP;
              cnt         <= CNT_W'(SKIP);
            end
          end
          default: state <= LOAD;
        endcase
      end
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.rnd_valid = rnd_valid_q;
  assign bus.rnd_data  = rnd_data_q;
  assign bus.seed_err  = seed_err_q;
  assign bus.busy      = (state != READY);

endmodule

// File: tb/tb_lfsr_rng_arbiter.sv
// Bench for lfsr_rng_arbiter: two parameterisations driven with the same
// directed + random stimulus and compared every cycle to a transaction-level model.
module tb_lfsr_rng_arbiter;

  localparam int          NREQ   = 4;
  localparam int          SKIP_A = 1;
  localparam int          WARM_A = 0;
  localparam int          SKIP_B = 4;
  localparam int          WARM_B = 3;
  localparam logic [63:0] DEF_A  = 64'h0;
  localparam logic [63:0] DEF_B  = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] ONES   = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk = 1'b0;
  logic reset;

  lfsr_rng_arbiter_if #(.NUM_REQ(NREQ)) bus_a ();
  lfsr_rng_arbiter_if #(.NUM_REQ(NREQ)) bus_b ();

  lfsr_rng_arbiter #(.NUM_REQ(NREQ), .SKIP(SKIP_A), .WARMUP(WARM_A), .DEFAULT_SEED(DEF_A))
    dut_a (.clk(clk), .reset(reset), .bus(bus_a.slave));
  lfsr_rng_arbiter #(.NUM_REQ(NREQ), .SKIP(SKIP_B), .WARMUP(WARM_B), .DEFAULT_SEED(DEF_B))
    dut_b (.clk(clk), .reset(reset), .bus(bus_b.slave));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: seed pending flag, remaining LFSR steps before the server is idle.
  logic [63:0] m_lfsr [2];
  logic [63:0] m_ldval[2];
  logic [63:0] m_data [2];
  bit          m_ldpend[2];
  bit          m_ldbad[2];
  int          m_steps[2];
  int          m_ptr  [2];
  logic [3:0]  m_gnt  [2];
  bit          m_valid[2];
  bit          m_err  [2];

  logic [63:0] qa[$], qb[$], ga[$], gb[$];
  int errc_a, errc_b;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] lfsr_adv(input logic [63:0] s, input int n);
    logic [63:0] v = s;
    for (int k = 0; k < n; k++) v = {v[62:0], ~(v[63] ^ v[62] ^ v[60] ^ v[59])};
    return v;
  endfunction

  function automatic logic [63:0] qat(input logic [63:0] q[$], input int k);
    if (k < q.size()) return q[k];
    return 'x;
  endfunction

  function automatic logic [63:0] def_of(input int d);  return d == 0 ? DEF_A : DEF_B;  endfunction
  function automatic int          skip_of(input int d); return d == 0 ? SKIP_A : SKIP_B; endfunction
  function automatic int          warm_of(input int d); return d == 0 ? WARM_A : WARM_B; endfunction

  task automatic model_reset(input int d);
    m_lfsr[d] = def_of(d); m_ldval[d] = def_of(d); m_ldpend[d] = 1'b1; m_ldbad[d] = 1'b0;
    m_steps[d] = 0; m_ptr[d] = 0; m_gnt[d] = '0; m_valid[d] = 1'b0; m_data[d] = '0; m_err[d] = 1'b0;
  endtask

  task automatic model_cycle(input int d, input bit sv, input logic [63:0] sd, input logic [3:0] rq);
    bit done = 1'b0;
    m_gnt[d] = '0; m_valid[d] = 1'b0; m_err[d] = 1'b0;
    if (sv) begin
      m_ldpend[d] = 1'b1; m_steps[d] = 0;
      m_ldbad[d]  = (sd == ONES);
      m_ldval[d]  = (sd == ONES) ? def_of(d) : sd;
    end else if (m_ldpend[d]) begin
      m_lfsr[d] = m_ldval[d]; m_err[d] = m_ldbad[d];
      m_ldpend[d] = 1'b0; m_steps[d] = warm_of(d);
    end else if (m_steps[d] > 0) begin
      m_lfsr[d] = lfsr_adv(m_lfsr[d], 1);
      m_steps[d]--;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        int idx = (m_ptr[d] + k) % NREQ;
        if (!done && (((rq >> idx) & 4'd1) != 4'd0)) begin
          done = 1'b1;
          m_gnt[d] = 4'b0001 << idx; m_valid[d] = 1'b1; m_data[d] = m_lfsr[d];
          m_ptr[d] = (idx + 1) % NREQ; m_steps[d] = skip_of(d);
        end
      end
    end
  endtask

  task automatic step_cycle(input bit rst, input bit sv, input logic [63:0] sd, input logic [3:0] rq);
    reset = rst;
    bus_a.seed_valid = sv; bus_a.seed = sd; bus_a.req = rq;
    bus_b.seed_valid = sv; bus_b.seed = sd; bus_b.req = rq;
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (rst) model_reset(d);
      else model_cycle(d, sv, sd, rq);
    end
    #1;
    check_val("a.gnt",   64'(bus_a.gnt),       64'(m_gnt[0]));
    check_val("a.valid", 64'(bus_a.rnd_valid), 64'(m_valid[0]));
    check_val("a.data",  bus_a.rnd_data,       m_data[0]);
    check_val("a.busy",  64'(bus_a.busy),      64'(m_ldpend[0] || m_steps[0] > 0));
    check_val("a.err",   64'(bus_a.seed_err),  64'(m_err[0]));
    check_val("b.gnt",   64'(bus_b.gnt),       64'(m_gnt[1]));
    check_val("b.valid", 64'(bus_b.rnd_valid), 64'(m_valid[1]));
    check_val("b.data",  bus_b.rnd_data,       m_data[1]);
    check_val("b.busy",  64'(bus_b.busy),      64'(m_ldpend[1] || m_steps[1] > 0));
    check_val("b.err",   64'(bus_b.seed_err),  64'(m_err[1]));
    if (bus_a.rnd_valid) begin qa.push_back(bus_a.rnd_data); ga.push_back(64'(bus_a.gnt)); end
    if (bus_b.rnd_valid) begin qb.push_back(bus_b.rnd_data); gb.push_back(64'(bus_b.gnt)); end
    if (bus_a.seed_err) errc_a++;
    if (bus_b.seed_err) errc_b++;
  endtask

  task automatic wait_b_ready();
    for (int k = 0; k < 50 && bus_b.busy; k++) step_cycle(1'b0, 1'b0, '0, 4'b0000);
    check_val("b.ready_wait", 64'(bus_b.busy), 64'd0);
  endtask

  function automatic logic [63:0] rotl4(input logic [63:0] g);
    logic [3:0] v = g[3:0];
    return 64'({v[2:0], v[3]});
  endfunction

  initial begin
    logic [63:0] s;
    int n;

    // Reset
    step_cycle(1'b1, 1'b0, '0, 4'b0000);
    step_cycle(1'b1, 1'b0, '0, 4'b0000);
    check_val("rst.busy_a", 64'(bus_a.busy), 64'd1);

    // Single requester: words 0, 1, 3 from the zero seed with SKIP=1
    qa.delete();
    repeat (10) step_cycle(1'b0, 1'b0, '0, 4'b0001);
    check_val("t1.w0", qat(qa, 0), 64'h0);
    check_val("t1.w1", qat(qa, 1), 64'h1);
    check_val("t1.w2", qat(qa, 2), 64'h3);

    // All requesting: grant rotates one position each time
    ga.delete();
    repeat (16) step_cycle(1'b0, 1'b0, '0, 4'b1111);
    check_val("t2.ngrants", 64'(ga.size() >= 7), 64'd1);
    for (int k = 1; k < ga.size(); k++) check_val("t2.rr", ga[k], rotl4(ga[k-1]));

    // Lock-up seed replaced by the default seed, error pulses once
    errc_a = 0; errc_b = 0; qa.delete(); qb.delete();
    step_cycle(1'b0, 1'b1, ONES, 4'b0000);
    repeat (20) step_cycle(1'b0, 1'b0, '0, 4'b1111);
    check_val("t3.errc_a", 64'(errc_a), 64'd1);
    check_val("t3.errc_b", 64'(errc_b), 64'd1);
    check_val("t3.word_a", qat(qa, 0), DEF_A);
    check_val("t3.word_b", qat(qb, 0), lfsr_adv(DEF_B, WARM_B));

    // Seed together with a request in READY: grant WARMUP+2 edges later
    wait_b_ready();
    s = {$urandom, $urandom};
    step_cycle(1'b0, 1'b1, s, 4'b1111);
    check_val("t4.nogrant", 64'(bus_b.gnt), 64'd0);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      step_cycle(1'b0, 1'b0, '0, 4'b1111);
      n++;
      if (bus_b.gnt != '0) break;
    end
    check_val("t4.latency", 64'(n), 64'(WARM_B + 2));
    check_val("t4.word", bus_b.rnd_data, lfsr_adv(s, WARM_B));

    // Seed on the 2nd step after a grant aborts the skip
    wait_b_ready();
    step_cycle(1'b0, 1'b0, '0, 4'b0001);
    check_val("t5.gnt", 64'(bus_b.gnt), 64'(m_gnt[1]));
    step_cycle(1'b0, 1'b0, '0, 4'b0000);
    s = {$urandom, $urandom};
    step_cycle(1'b0, 1'b1, s, 4'b0000);
    qb.delete();
    for (int k = 0; k < 40 && qb.size() == 0; k++) step_cycle(1'b0, 1'b0, '0, 4'b1111);
    check_val("t5.word", qat(qb, 0), lfsr_adv(s, WARM_B));

    // Reset in the middle of warm-up
    s = {$urandom, $urandom};
    step_cycle(1'b0, 1'b1, s, 4'b0000);
    step_cycle(1'b0, 1'b0, '0, 4'b1111);
    step_cycle(1'b0, 1'b0, '0, 4'b1111);
    step_cycle(1'b1, 1'b0, '0, 4'b1111);
    check_val("t6.gnt_b",   64'(bus_b.gnt),       64'd0);
    check_val("t6.valid_b", 64'(bus_b.rnd_valid), 64'd0);
    qa.delete(); qb.delete(); ga.delete(); gb.delete();
    repeat (12) step_cycle(1'b0, 1'b0, '0, 4'b1111);
    check_val("t6.gnt_a",  qat(ga, 0), 64'd1);
    check_val("t6.word_a", qat(qa, 0), DEF_A);
    check_val("t6.gnt_b0", qat(gb, 0), 64'd1);
    check_val("t6.word_b", qat(qb, 0), lfsr_adv(DEF_B, WARM_B));

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      bit          rst = ($urandom_range(0, 99) == 0);
      bit          sv  = ($urandom_range(0, 19) == 0);
      logic [63:0] sd  = ($urandom_range(0, 3) == 0) ? ONES : {$urandom, $urandom};
      logic [3:0]  rq  = 4'($urandom_range(0, 15));
      step_cycle(rst, sv, sd, rq);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
